// File: rtl/model_test_mac_relu.sv
// Multiply-accumulate reduction stage: sums N_TAPS signed products seeded with a bias,
// realigns by an arithmetic shift, then applies ReLU with unsigned saturation.
module model_test_mac_relu #(
   parameter int PROD_WIDTH = 19,
   parameter int BIAS_WIDTH = 12,
   parameter int N_TAPS     = 27,
   parameter int ACC_WIDTH  = 24,
   parameter int SHIFT      = 6,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [PROD_WIDTH-1:0] prod_tdata,
   input  logic                  prod_tvalid,
   output logic                  prod_tready,
   input  logic [BIAS_WIDTH-1:0] bias,
   output logic [OUT_WIDTH-1:0]  out_tdata,
   output logic                  out_tvalid,
   input  logic                  out_tready
);

   localparam int CNT_WIDTH = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(N_TAPS - 1);

   typedef enum logic {ACC, OUT} state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   tap_cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic signed [ACC_WIDTH-1:0] sum;
   logic signed [ACC_WIDTH-1:0] shifted;
   logic [OUT_WIDTH-1:0]   act;
   logic                   accept;

   assign accept = prod_tvalid && prod_tready;

   // The first tap of a group replaces the running sum with the sign-extended bias.
   always_comb begin
      acc_base = acc;
      if (tap_cnt == '0) begin
         acc_base = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
      end
      sum     = acc_base + {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
      shifted = sum >>> SHIFT;
      act     = shifted[OUT_WIDTH-1:0];
      if (shifted[ACC_WIDTH-1]) begin
         act = '0;
      end else if (|shifted[ACC_WIDTH-2:OUT_WIDTH]) begin
         act = '1;
      end
   end

   // prod_tready is registered so it stays low through reset and while a result is pending.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state       <= ACC;
         tap_cnt     <= '0;
         acc         <= '0;
         out_tdata   <= '0;
         out_tvalid  <= 1'b0;
         prod_tready <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               prod_tready <= 1'b1;
               if (accept) begin
                  acc <= sum;
                  if (tap_cnt == LAST_TAP) begin
                     tap_cnt     <= '0;
                     out_tdata   <= act;
                     out_tvalid  <= 1'b1;
                     prod_tready <= 1'b0;
                     state       <= OUT;
                  end else begin
                     tap_cnt <= tap_cnt + CNT_WIDTH'(1);
                  end
               end
            end
            OUT: begin
               if (out_tready) begin
                  out_tvalid  <= 1'b0;
                  prod_tready <= 1'b1;
                  state       <= ACC;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_model_test_mac_relu.sv
// Directed bench for model_test_mac_relu with a transaction-level reference model
// and a per-cycle compare process.
module tb_model_test_mac_relu;

   localparam int N_TAPS    = 4;
   localparam int SHIFT     = 2;
   localparam int OUT_WIDTH = 8;

   logic              ap_clk;
   logic              ap_rst_n;
   logic signed [18:0] prod_tdata;
   logic              prod_tvalid;
   logic              prod_tready;
   logic signed [11:0] bias;
   logic [OUT_WIDTH-1:0] out_tdata;
   logic              out_tvalid;
   logic              out_tready;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   int grp[$];
   int grp_bias;
   int exp_ready;
   int exp_valid;
   int exp_data;

   model_test_mac_relu #(
      .PROD_WIDTH(19), .BIAS_WIDTH(12), .N_TAPS(N_TAPS),
      .ACC_WIDTH(24), .SHIFT(SHIFT), .OUT_WIDTH(OUT_WIDTH)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .prod_tdata(prod_tdata), .prod_tvalid(prod_tvalid), .prod_tready(prod_tready),
      .bias(bias),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Activation straight from the arithmetic definition: wrap to 24 bits, floor-shift, clamp.
   function automatic int activation(input int b, input int q[$]);
      longint s;
      logic signed [23:0] w;
      int t;
      s = b;
      foreach (q[i]) s += q[i];
      w = s[23:0];
      t = int'(w) >>> SHIFT;
      if (t < 0) return 0;
      if (t > (1 << OUT_WIDTH) - 1) return (1 << OUT_WIDTH) - 1;
      return t;
   endfunction

   always @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         grp.delete();
         exp_ready = 0;
         exp_valid = 0;
         exp_data  = 0;
      end else if (exp_valid != 0) begin
         if (out_tready) begin
            exp_valid = 0;
            exp_ready = 1;
         end
      end else begin
         if (exp_ready != 0 && prod_tvalid) begin
            if (grp.size() == 0) grp_bias = int'(bias);
            grp.push_back(int'(prod_tdata));
            if (grp.size() == N_TAPS) begin
               exp_data  = activation(grp_bias, grp);
               exp_valid = 1;
               grp.delete();
            end
         end
         exp_ready = (exp_valid == 0) ? 1 : 0;
      end
   end

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   always @(negedge ap_clk) begin
      if (cmp_en) begin
         check_output("cmp_prod_tready", int'(prod_tready), exp_ready);
         check_output("cmp_out_tvalid", int'(out_tvalid), exp_valid);
         if (exp_valid != 0) check_output("cmp_out_tdata", int'(out_tdata), exp_data);
      end
   end

   // Drives n taps; bias b0 on the first tap, b_rest afterwards. Ends on the negedge after the last accept.
   task automatic apply_stimulus(input int b0, input int b_rest, input int p[4],
                                 input int n, input int gap);
      int w;
      for (int i = 0; i < n; i++) begin
         prod_tvalid = 1'b1;
         prod_tdata  = 19'(p[i]);
         if (i == 0) bias = 12'(b0);
         w = 0;
         while (!prod_tready && w < 20) begin
            @(negedge ap_clk);
            w++;
         end
         if (!prod_tready) begin
            errors++;
            checks++;
            $display("[TB] FAIL ready_timeout: got prod_tready=0, expected 1 within 20 cycles");
         end
         @(negedge ap_clk);
         prod_tvalid = 1'b0;
         bias = 12'(b_rest);
         if (i < n - 1) repeat (gap) @(negedge ap_clk);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ap_rst_n    = 1'b0;
      prod_tvalid = 1'b0;
      prod_tdata  = '0;
      bias        = '0;
      out_tready  = 1'b1;
      @(negedge ap_clk);
      @(negedge ap_clk);
      check_output("reset_out_tvalid", int'(out_tvalid), 0);
      check_output("reset_out_tdata", int'(out_tdata), 0);
      check_output("reset_prod_tready", int'(prod_tready), 0);
      cmp_en   = 1;
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check_output("ready_after_reset", int'(prod_tready), 1);

      $display("[TB] basic group");
      apply_stimulus(10, 10, '{100, -20, 30, 4}, 4, 0);
      check_output("basic_tvalid", int'(out_tvalid), 1);
      check_output("basic_tready", int'(prod_tready), 0);
      check_output("basic_tdata", int'(out_tdata), 31);
      check_output("basic_model", exp_data, 31);
      @(negedge ap_clk);

      $display("[TB] relu clamp");
      apply_stimulus(-5, -5, '{-100, 3, 2, 1}, 4, 0);
      check_output("relu_tdata", int'(out_tdata), 0);
      check_output("relu_model", exp_data, 0);
      @(negedge ap_clk);

      $display("[TB] saturation");
      apply_stimulus(2047, 2047, '{262143, 262143, 262143, 262143}, 4, 0);
      check_output("sat_tdata", int'(out_tdata), 255);
      check_output("sat_model", exp_data, 255);
      @(negedge ap_clk);

      $display("[TB] backpressure");
      out_tready = 1'b0;
      apply_stimulus(10, 10, '{100, -20, 30, 4}, 4, 0);
      for (int c = 0; c < 5; c++) begin
         check_output("bp_tdata", int'(out_tdata), 31);
         check_output("bp_tvalid", int'(out_tvalid), 1);
         check_output("bp_tready", int'(prod_tready), 0);
         @(negedge ap_clk);
      end
      out_tready = 1'b1;
      @(negedge ap_clk);
      check_output("bp_released", int'(out_tvalid), 0);
      apply_stimulus(0, 0, '{4, 4, 4, 4}, 4, 0);
      check_output("bp_next_tdata", int'(out_tdata), 4);
      @(negedge ap_clk);

      $display("[TB] bubbles and bias sampling");
      apply_stimulus(7, 1000, '{12, 16, 20, 24}, 4, 2);
      check_output("bubble_tdata", int'(out_tdata), 19);
      check_output("bubble_model", exp_data, 19);
      @(negedge ap_clk);

      $display("[TB] reset mid-group");
      apply_stimulus(100, 100, '{40, 40, 0, 0}, 2, 0);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      check_output("rst_mid_tready", int'(prod_tready), 0);
      ap_rst_n = 1'b1;
      apply_stimulus(0, 0, '{8, 8, 8, 8}, 4, 0);
      check_output("rst_mid_tdata", int'(out_tdata), 8);
      @(negedge ap_clk);

      $display("[TB] reset with pending result");
      out_tready = 1'b0;
      apply_stimulus(0, 0, '{8, 8, 8, 8}, 4, 0);
      check_output("rst_out_pending", int'(out_tvalid), 1);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      check_output("rst_out_tvalid", int'(out_tvalid), 0);
      check_output("rst_out_tdata", int'(out_tdata), 0);
      ap_rst_n   = 1'b1;
      out_tready = 1'b1;
      repeat (3) @(negedge ap_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
